ifu: RTL and testbench

Instruction fetch unit for the multicycle NPC core. It holds the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a request/response handshake, and hands it with its PC to the decode stage over a valid/ready handshake. It then waits for the next PC from the commit path before fetching again. Fetch stops permanently on halt (EBREAK) or on a misaligned next PC, until reset.

---
 rtl/ifu.sv | 101 ++++++++++
 tb/tb_ifu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// ifu: instruction fetch unit for the multicycle NPC core; one instruction in flight at a time.
// Latency: zero-wait memory gives FETCH->WAIT->ISSUE, so inst_valid rises 3 cycles after npc_valid.
// Backpressure: req_ready stalls hold FETCH, slow responses hold WAIT, inst_ready stalls hold ISSUE.
//
// Ports:
//   clk, rst                          core clock, synchronous active-high reset
//   imem_req_valid/ready/addr         fetch request to instruction memory (addr always equals pc)
//   imem_rsp_valid/data               single-cycle response pulse carrying the instruction word
//   inst_valid/ready, inst, pc        instruction handed to decode with its PC
//   npc_valid, npc, halt              commit of the issued instruction and its successor PC
//   halted, fetch_err                 sticky stop causes (EBREAK, misaligned npc)
//   retired                           committed-instruction count, wraps at 2^32
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retired;
  logic        r_halted;
  logic        r_fetch_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_retired   <= 32'd0;
      r_halted    <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        // Request is valid for the whole FETCH state, so ready alone completes it.
        S_FETCH: if (imem_req_ready) r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_inst  <= imem_rsp_data;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: if (inst_ready) r_state <= S_EXEC;
        S_EXEC: begin
          if (npc_valid) begin
            r_retired <= r_retired + 32'd1;
            // halt outranks a misaligned npc; neither stop cause moves pc.
            if (halt) begin
              r_halted <= 1'b1;
              r_state  <= S_STOP;
            end else if (npc[1:0] != 2'b00) begin
              r_fetch_err <= 1'b1;
              r_state     <= S_STOP;
            end else begin
              r_pc    <= npc;
              r_state <= S_FETCH;
            end
          end
        end
        S_STOP: r_state <= S_STOP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Masked by rst so no request is presented during the reset cycle itself.
  assign imem_req_valid = (r_state == S_FETCH) && !rst;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_ISSUE);
  assign inst           = r_inst;
  assign pc             = r_pc;
  assign halted         = r_halted;
  assign fetch_err      = r_fetch_err;
  assign retired        = r_retired;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        npc_valid;
  logic [31:0] npc;
  logic        halt;
  logic        halted;
  logic        fetch_err;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // Architectural reference model: what the fetch unit should expose.
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_halted;
  logic        m_err;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .npc_valid(npc_valid), .npc(npc), .halt(halt),
    .halted(halted), .fetch_err(fetch_err), .retired(retired)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b0;
    npc_valid      = 1'b0;
    npc            = 32'd0;
    halt           = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    m_pc = RST_PC; m_retired = 0; m_halted = 0; m_err = 0;
  endtask

  // One full fetch from the FETCH cycle through the decode handshake; ends in the first EXEC cycle.
  task automatic fetch_one(input int req_stall, input int rsp_delay, input int iss_stall,
                           input logic [31:0] word, input bit spurious);
    for (int i = 0; i <= req_stall; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_req cyc%0d: valid=%b addr=%h inst_valid=%b, expected valid=1 addr=%h inst_valid=0",
                 i, imem_req_valid, imem_req_addr, inst_valid, m_pc);
      end
      imem_req_ready = (i == req_stall);
      tick();
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i <= rsp_delay; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_idle cyc%0d: req_valid=%b inst_valid=%b, expected 0 0", i, imem_req_valid, inst_valid);
      end
      imem_req_ready = spurious;
      imem_rsp_valid = (i == rsp_delay);
      imem_rsp_data  = (i == rsp_delay) ? word : $urandom;
      halt           = spurious;
      tick();
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    halt           = 1'b0;
    for (int i = 0; i <= iss_stall; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst !== word || pc !== m_pc || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL issue cyc%0d: inst_valid=%b inst=%h pc=%h req_valid=%b, expected 1 %h %h 0",
                 i, inst_valid, inst, pc, imem_req_valid, word, m_pc);
      end
      inst_ready = (i == iss_stall);
      npc_valid  = spurious;
      npc        = $urandom;
      tick();
    end
    inst_ready = 1'b0;
    npc_valid  = 1'b0;
  endtask

  // Commit from EXEC after 'delay' idle cycles, then compare architectural state to the model.
  task automatic commit(input int delay, input logic [31:0] nv, input logic hv, input bit spurious);
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || retired !== m_retired) begin
        errors++;
        $display("FAIL exec_idle cyc%0d: inst_valid=%b req_valid=%b retired=%0d, expected 0 0 %0d",
                 i, inst_valid, imem_req_valid, retired, m_retired);
      end
      imem_rsp_valid = spurious;
      imem_rsp_data  = $urandom;
      npc_valid      = (i == delay);
      npc            = (i == delay) ? nv : $urandom;
      halt           = (i == delay) ? hv : spurious;
      tick();
    end
    clear_inputs();
    m_retired = m_retired + 1;
    if (hv) m_halted = 1'b1;
    else if (nv[1:0] != 2'b00) m_err = 1'b1;
    else m_pc = nv;
    checks++;
    if (retired !== m_retired || halted !== m_halted || fetch_err !== m_err || pc !== m_pc) begin
      errors++;
      $display("FAIL commit: retired=%0d halted=%b err=%b pc=%h, expected %0d %b %b %h",
               retired, halted, fetch_err, pc, m_retired, m_halted, m_err, m_pc);
    end
  endtask

  // Stopped unit must ignore everything and present no handshakes.
  task automatic check_stopped(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = $urandom_range(0, 1);
      inst_ready     = 1'b1;
      npc_valid      = 1'b1;
      npc            = $urandom & 32'hFFFF_FFFC;
      halt           = $urandom_range(0, 1);
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== m_pc || retired !== m_retired ||
          halted !== m_halted || fetch_err !== m_err) begin
        errors++;
        $display("FAIL stopped cyc%0d: req=%b iv=%b pc=%h ret=%0d h=%b e=%b, expected 0 0 %h %0d %b %b",
                 i, imem_req_valid, inst_valid, pc, retired, halted, fetch_err, m_pc, m_retired, m_halted, m_err);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RST_PC || inst !== 32'd0 ||
          retired !== 32'd0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: req=%b iv=%b pc=%h inst=%h ret=%0d h=%b e=%b, expected 0 0 %h 0 0 0 0",
                 i, imem_req_valid, inst_valid, pc, inst, retired, halted, fetch_err, RST_PC);
      end
    end
    rst = 1'b0;
    #1;
    m_pc = RST_PC; m_retired = 0; m_halted = 0; m_err = 0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h, expected 1 80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_zero_wait;
    fetch_one(0, 0, 0, 32'h0000_0413, 1'b0);
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 3; k++) begin
      commit(0, m_pc + 32'd4, 1'b0, 1'b0);
      fetch_one(0, 0, 0, $urandom | 32'd1, 1'b0);
    end
    checks++;
    if (retired !== 32'd3 || pc !== 32'h8000_000C) begin
      errors++;
      $display("FAIL sequential: retired=%0d pc=%h, expected 3 8000000c", retired, pc);
    end
  endtask

  task automatic test_backpressure;
    commit(0, m_pc + 32'd4, 1'b0, 1'b0);
    fetch_one(4, 5, 3, $urandom | 32'd1, 1'b0);
  endtask

  task automatic test_redirect;
    commit(2, 32'h8000_1000, 1'b0, 1'b1);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000) begin
      errors++;
      $display("FAIL redirect: req=%b addr=%h, expected 1 80001000", imem_req_valid, imem_req_addr);
    end
    fetch_one(1, 2, 2, $urandom | 32'd1, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 25; k++) begin
      commit($urandom_range(0, 3), RST_PC + ($urandom_range(0, 1023) << 2), 1'b0, $urandom_range(0, 1) == 1);
      fetch_one($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom | 32'd1, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_halt;
    logic [31:0] pc_before;
    pc_before = m_pc;
    commit($urandom_range(0, 2), m_pc + 32'd4, 1'b1, 1'b0);
    checks++;
    if (halted !== 1'b1 || pc !== pc_before || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL halt: halted=%b pc=%h err=%b, expected 1 %h 0", halted, pc, fetch_err, pc_before);
    end
    check_stopped(5);
  endtask

  task automatic test_error;
    do_reset();
    fetch_one(0, 0, 0, $urandom | 32'd1, 1'b0);
    commit(0, 32'h8000_0002, 1'b0, 1'b0);
    checks++;
    if (fetch_err !== 1'b1 || halted !== 1'b0 || pc !== 32'h8000_0000 || retired !== 32'd1) begin
      errors++;
      $display("FAIL misalign: err=%b halted=%b pc=%h ret=%0d, expected 1 0 80000000 1",
               fetch_err, halted, pc, retired);
    end
    check_stopped(4);
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    fetch_one(0, 1, 0, 32'hDEAD_BEEF, 1'b0);
    commit(0, 32'h8000_0040, 1'b0, 1'b0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RST_PC || inst !== 32'd0 ||
        retired !== 32'd0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: req=%b iv=%b pc=%h inst=%h ret=%0d h=%b e=%b, expected 0 0 %h 0 0 0 0",
               imem_req_valid, inst_valid, pc, inst, retired, halted, fetch_err, RST_PC);
    end
    rst = 1'b0;
    #1;
    m_pc = RST_PC; m_retired = 0; m_halted = 0; m_err = 0;
    fetch_one(0, 0, 1, 32'h0000_0013, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_zero_wait();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_random();
    test_halt();
    test_error();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
